// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: move/grow strobes, direction commit with reversal rejection,
// length and saturating score tracking, and game-over handling.
module snake_game_ctrl #(
    parameter int TICK_DIV = 2500000,
    parameter int MAX_LEN  = 32,
    parameter int SCORE_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               btn_right,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_up,
    input  logic               food_hit,
    input  logic               collide,
    output logic               step,
    output logic               grow,
    output logic               dead,
    output logic [1:0]         dir,
    output logic [5:0]         length,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         state
);

    localparam int                 CNT_W     = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [5:0]         LEN_MAX   = 6'(MAX_LEN);
    localparam logic [SCORE_W-1:0] SCORE_SAT = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_CHECK = 2'd2,
        S_OVER  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         dir_q, dir_d;
    logic [1:0]         pend_q, pend_d;
    logic [5:0]         len_q, len_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               start_q;
    logic               step_q, step_d;
    logic               grow_q, grow_d;
    logic               dead_q, dead_d;

    logic               rise;
    logic               cand_valid;
    logic [1:0]         cand;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dir_q   <= 2'd0;
            pend_q  <= 2'd0;
            len_q   <= 6'd1;
            score_q <= '0;
            start_q <= 1'b0;
            step_q  <= 1'b0;
            grow_q  <= 1'b0;
            dead_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
            len_q   <= len_d;
            score_q <= score_d;
            start_q <= start;
            step_q  <= step_d;
            grow_q  <= grow_d;
            dead_q  <= dead_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        pend_d     = pend_q;
        len_d      = len_q;
        score_d    = score_q;
        step_d     = 1'b0;
        grow_d     = 1'b0;
        dead_d     = dead_q;
        rise       = start & ~start_q;
        cand_valid = 1'b1;
        cand       = 2'd0;

        if (btn_up)         cand = 2'd3;
        else if (btn_left)  cand = 2'd2;
        else if (btn_down)  cand = 2'd1;
        else if (btn_right) cand = 2'd0;
        else                cand_valid = 1'b0;

        // Reversal is judged against the committed direction, not the pending one
        if (state_q != S_OVER && cand_valid && cand != (dir_q ^ 2'd2)) begin
            pend_d = cand;
        end

        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    dir_d   = pend_q;
                    step_d  = 1'b1;
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CHECK: begin
                if (collide) begin
                    state_d = S_OVER;
                    dead_d  = 1'b1;
                end else begin
                    state_d = S_RUN;
                    if (food_hit) begin
                        if (score_q != SCORE_SAT) score_d = score_q + SCORE_W'(1);
                        if (len_q < LEN_MAX) begin
                            len_d  = len_q + 6'd1;
                            grow_d = 1'b1;
                        end
                    end
                end
            end
            S_OVER: begin
                if (rise) begin
                    state_d = S_IDLE;
                    len_d   = 6'd1;
                    score_d = '0;
                    dir_d   = 2'd0;
                    pend_d  = 2'd0;
                    dead_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign step   = step_q;
    assign grow   = grow_q;
    assign dead   = dead_q;
    assign dir    = dir_q;
    assign length = len_q;
    assign score  = score_q;
    assign state  = state_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Self-checking bench for snake_game_ctrl: vector table, corner sequences and
// randomized play checked against a behavioural game model.
module tb_snake_game_ctrl;

    localparam int TD   = 4;
    localparam int MAXL = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       btn_right = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_up = 1'b0;
    logic       food_hit = 1'b0, collide = 1'b0;
    logic       step, grow, dead;
    logic [1:0] dir, state;
    logic [5:0] length;
    logic [7:0] score;

    logic       step3, grow3, dead3;
    logic [1:0] dir3, state3;
    logic [5:0] length3;
    logic [2:0] score3;

    int errors = 0;
    int checks = 0;

    int mState, mCnt, mDir, mPend, mLen, mScore, mStep, mGrow, mDead, mStartPrev;

    snake_game_ctrl #(.TICK_DIV(TD), .MAX_LEN(MAXL), .SCORE_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .btn_right(btn_right), .btn_down(btn_down), .btn_left(btn_left), .btn_up(btn_up),
        .food_hit(food_hit), .collide(collide),
        .step(step), .grow(grow), .dead(dead), .dir(dir),
        .length(length), .score(score), .state(state)
    );

    snake_game_ctrl #(.TICK_DIV(TD), .MAX_LEN(MAXL), .SCORE_W(3)) dutSat (
        .clk(clk), .rst_n(rst_n), .start(start),
        .btn_right(btn_right), .btn_down(btn_down), .btn_left(btn_left), .btn_up(btn_up),
        .food_hit(food_hit), .collide(collide),
        .step(step3), .grow(grow3), .dead(dead3), .dir(dir3),
        .length(length3), .score(score3), .state(state3)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic int satMin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    function automatic void modelReset();
        mState = 0; mCnt = 0; mDir = 0; mPend = 0; mLen = 1; mScore = 0;
        mStep = 0; mGrow = 0; mDead = 0; mStartPrev = 0;
    endfunction

    // Game rules as one clock-edge step; b = {up, left, down, right}
    function automatic void modelUpdate(logic st, logic [3:0] b, logic f, logic c);
        int  cand;
        int  newPend;
        bit  rise;
        rise       = st && (mStartPrev == 0);
        mStartPrev = int'(st);
        mStep      = 0;
        mGrow      = 0;
        newPend    = mPend;
        cand       = b[3] ? 3 : b[2] ? 2 : b[1] ? 1 : b[0] ? 0 : -1;
        if (mState != 3 && cand >= 0 && cand != (mDir ^ 2)) newPend = cand;
        case (mState)
            0: if (rise) begin mState = 1; mCnt = 0; end
            1: begin
                if (mCnt == TD - 1) begin
                    mCnt = 0; mDir = mPend; mStep = 1; mState = 2;
                end else mCnt++;
            end
            2: begin
                if (c) begin
                    mState = 3; mDead = 1;
                end else begin
                    mState = 1;
                    if (f) begin
                        mScore++;
                        if (mLen < MAXL) begin mLen++; mGrow = 1; end
                    end
                end
            end
            default: if (rise) begin
                mState = 0; mLen = 1; mScore = 0; mDir = 0; newPend = 0; mDead = 0;
            end
        endcase
        mPend = newPend;
    endfunction

    task automatic checkOutput();
        chk("state", int'(state), mState);
        chk("step", int'(step), mStep);
        chk("grow", int'(grow), mGrow);
        chk("dead", int'(dead), mDead);
        chk("dir", int'(dir), mDir);
        chk("length", int'(length), mLen);
        chk("score", int'(score), satMin(mScore, 255));
        chk("scoreSat3", int'(score3), satMin(mScore, 7));
        chk("stepGrowExcl", int'(step & grow), 0);
    endtask

    task automatic applyStimulus(input logic st, input logic [3:0] b, input logic f, input logic c);
        start = st;
        {btn_up, btn_left, btn_down, btn_right} = b;
        food_hit = f;
        collide  = c;
        modelUpdate(st, b, f, c);
        @(posedge clk);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        {btn_up, btn_left, btn_down, btn_right} = 4'b0;
        food_hit = 1'b0;
        collide  = 1'b0;
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput();
    endtask

    typedef struct {
        logic       st;
        logic [3:0] b;
        logic       f;
        logic       c;
        int         n;
        int         eState, eDir, eLen, eScore, eDead, eStep, eGrow;
    } vec_t;

    vec_t vecs[16];

    initial begin
        int growCnt;
        int found;

        //          st  b        f     c     n  state dir len sc dead step grow
        vecs[0]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 1, 1, 0, 1, 0, 0, 0, 0};
        vecs[1]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 3, 1, 0, 1, 0, 0, 0, 0};
        vecs[2]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1, 2, 0, 1, 0, 0, 1, 0};
        vecs[3]  = '{1'b0, 4'b0100, 1'b0, 1'b0, 1, 1, 0, 1, 0, 0, 0, 0};
        vecs[4]  = '{1'b0, 4'b1000, 1'b0, 1'b0, 1, 1, 0, 1, 0, 0, 0, 0};
        vecs[5]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 3, 2, 3, 1, 0, 0, 1, 0};
        vecs[6]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1, 1, 3, 2, 1, 0, 0, 1};
        vecs[7]  = '{1'b0, 4'b0010, 1'b0, 1'b0, 1, 1, 3, 2, 1, 0, 0, 0};
        vecs[8]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 3, 2, 3, 2, 1, 0, 1, 0};
        vecs[9]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 1, 3, 3, 2, 1, 1, 0, 0};
        vecs[10] = '{1'b0, 4'b0000, 1'b0, 1'b0, 2, 3, 3, 2, 1, 1, 0, 0};
        vecs[11] = '{1'b1, 4'b0000, 1'b0, 1'b0, 1, 0, 0, 1, 0, 0, 0, 0};
        vecs[12] = '{1'b1, 4'b0100, 1'b0, 1'b0, 1, 0, 0, 1, 0, 0, 0, 0};
        vecs[13] = '{1'b0, 4'b0010, 1'b0, 1'b0, 1, 0, 0, 1, 0, 0, 0, 0};
        vecs[14] = '{1'b1, 4'b0000, 1'b0, 1'b0, 1, 1, 0, 1, 0, 0, 0, 0};
        vecs[15] = '{1'b0, 4'b0100, 1'b0, 1'b0, 4, 2, 1, 1, 0, 0, 1, 0};

        $display("[TB] reset and vector table");
        doReset();
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < vecs[i].n; k++)
                applyStimulus(vecs[i].st, vecs[i].b, vecs[i].f, vecs[i].c);
            chk($sformatf("vec%0d.state", i), int'(state), vecs[i].eState);
            chk($sformatf("vec%0d.dir", i), int'(dir), vecs[i].eDir);
            chk($sformatf("vec%0d.length", i), int'(length), vecs[i].eLen);
            chk($sformatf("vec%0d.score", i), int'(score), vecs[i].eScore);
            chk($sformatf("vec%0d.dead", i), int'(dead), vecs[i].eDead);
            chk($sformatf("vec%0d.step", i), int'(step), vecs[i].eStep);
            chk($sformatf("vec%0d.grow", i), int'(grow), vecs[i].eGrow);
        end

        $display("[TB] growth to max length with continuous food");
        doReset();
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
        growCnt = 0;
        for (int k = 0; k < 202; k++) begin
            applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
            if (grow) growCnt++;
        end
        chk("growPulses", growCnt, 31);
        chk("maxLength", int'(length), 32);
        chk("score40", int'(score), 40);
        chk("scoreSat7", int'(score3), 7);

        $display("[TB] asynchronous reset while step is high");
        doReset();
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            applyStimulus(1'b0, 4'b0001, 1'b0, 1'b0);
            if (step) found = 1;
        end
        chk("stepSeenBeforeReset", found, 1);
        rst_n = 1'b0;
        #1;
        chk("asyncStep", int'(step), 0);
        chk("asyncState", int'(state), 0);
        chk("asyncDir", int'(dir), 0);
        chk("asyncLength", int'(length), 1);
        chk("asyncScore", int'(score), 0);
        chk("asyncDead", int'(dead), 0);
        modelReset();
        start = 1'b0;
        {btn_up, btn_left, btn_down, btn_right} = 4'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput();

        $display("[TB] randomized play against model");
        for (int k = 0; k < 3000; k++) begin
            applyStimulus(($urandom_range(0, 15) == 0),
                          4'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 19) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
